// File: rtl/handshake_rx_buffer.sv
// handshake_rx_buffer: 4-phase valid/ack receiver feeding a first-word-fall-through FIFO
// drained over a valid/ready interface.
module handshake_rx_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    in_ack,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, ACK} state_t;
    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic                  push, pop, ack_next;
    assign full      = count == (AW+1)'(DEPTH);
    assign out_valid = count != '0;
    assign out_data  = mem[rd_ptr];
    assign push      = state == IDLE && in_valid && !full;
    assign pop       = out_valid && out_ready;
    // ACK is held for the rest of the in_valid high period, so only one capture per word
    assign ack_next  = state == IDLE ? push : in_valid;
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state  <= IDLE;
            in_ack <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state  <= ack_next ? ACK : IDLE;
            in_ack <= ack_next;
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
endmodule

// File: tb/tb_handshake_rx_buffer.sv
// tb_handshake_rx_buffer: directed 4-phase sender and stalling consumer, checked every cycle
// against a queue model of the receive buffer plus literal expectations.
module tb_handshake_rx_buffer;
    localparam int DW = 8;
    localparam int DEPTH = 4;
    logic          clk = 0;
    logic          rstn = 0;
    logic          in_valid = 0;
    logic [DW-1:0] in_data = '0;
    logic          in_ack;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_ready = 0;
    logic [2:0]    count;
    logic          full;
    int            errors = 0;
    int            checks = 0;
    logic [DW-1:0] q[$];
    logic          held = 0;

    handshake_rx_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_data(in_data), .in_ack(in_ack),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .count(count), .full(full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a word is taken once per in_valid high period if there is room; a pop needs a nonempty queue
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            q.delete();
            held <= 1'b0;
        end else begin
            automatic bit do_pop = q.size() != 0 && out_ready;
            automatic bit do_cap = in_valid && !held && q.size() < DEPTH;
            automatic logic [DW-1:0] d = in_data;
            if (do_pop) void'(q.pop_front());
            if (do_cap) q.push_back(d);
            held <= in_valid && (held || do_cap);
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            chk("count", 32'(count), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("full", 32'(full), 32'(q.size() == DEPTH));
            chk("in_ack", 32'(in_ack), 32'(held));
            if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic v);
        int n = 0;
        while (in_ack !== v && n < 50) begin
            step();
            n++;
        end
        if (in_ack !== v) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: in_ack=%b expected %b", in_ack, v);
        end
    endtask

    task automatic send(input logic [DW-1:0] d);
        in_valid = 1;
        in_data = d;
        wait_ack(1);
        in_valid = 0;
        wait_ack(0);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1;
        while (count != 0 && n < 50) begin
            step();
            n++;
        end
        out_ready = 0;
        chk("drain_count", 32'(count), 0);
    endtask

    initial begin
        #12 rstn = 1;
        step();
        chk("rst_in_ack", 32'(in_ack), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_full", 32'(full), 0);
        chk("rst_out_data", 32'(out_data), 0);
        // 2: streaming with a ready consumer
        out_ready = 1;
        send(8'hA1);
        send(8'hB2);
        send(8'hD8);
        step();
        chk("t2_count", 32'(count), 0);
        out_ready = 0;
        // 3: fill, back-pressure the sender, then free one slot
        send(8'hA1);
        send(8'hB2);
        send(8'hD8);
        send(8'hFF);
        chk("t3_count_full", 32'(count), 4);
        chk("t3_full", 32'(full), 1);
        in_valid = 1;
        in_data = 8'hC9;
        repeat (3) step();
        chk("t3_held_ack", 32'(in_ack), 0);
        chk("t3_held_count", 32'(count), 4);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("t3_pop_count", 32'(count), 3);
        chk("t3_pop_head", 32'(out_data), 32'h B2);
        chk("t3_no_push_ack", 32'(in_ack), 0);
        step();
        chk("t3_cap_ack", 32'(in_ack), 1);
        chk("t3_cap_count", 32'(count), 4);
        in_valid = 0;
        wait_ack(0);
        drain();
        // 4: simultaneous push and pop at count=2
        send(8'h11);
        send(8'h22);
        in_valid = 1;
        in_data = 8'h33;
        out_ready = 1;
        step();
        out_ready = 0;
        chk("t4_count", 32'(count), 2);
        chk("t4_head", 32'(out_data), 32'h22);
        chk("t4_ack", 32'(in_ack), 1);
        in_valid = 0;
        wait_ack(0);
        drain();
        // 5: long valid pulse yields a single capture
        in_valid = 1;
        in_data = 8'h5A;
        repeat (10) step();
        chk("t5_count", 32'(count), 1);
        chk("t5_ack_high", 32'(in_ack), 1);
        in_valid = 0;
        step();
        chk("t5_ack_low", 32'(in_ack), 0);
        chk("t5_count_after", 32'(count), 1);
        chk("t5_head", 32'(out_data), 32'h5A);
        drain();
        // 6: asynchronous reset mid-handshake
        send(8'h01);
        send(8'h02);
        in_valid = 1;
        in_data = 8'h03;
        wait_ack(1);
        chk("t6_count3", 32'(count), 3);
        #2 rstn = 0;
        #1;
        chk("t6_rst_ack", 32'(in_ack), 0);
        chk("t6_rst_valid", 32'(out_valid), 0);
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_data", 32'(out_data), 0);
        in_data = 8'hC9;
        #3 rstn = 1;
        step();
        chk("t6_new_count", 32'(count), 1);
        chk("t6_new_head", 32'(out_data), 32'hC9);
        chk("t6_new_ack", 32'(in_ack), 1);
        in_valid = 0;
        wait_ack(0);
        drain();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
